// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type codes, type-field position, header field
// offsets and header assembly, used by both the transmit and receive sides.
package noc_pkg;

   localparam logic [1:0] FLIT_HEADER  = 2'b10;
   localparam logic [1:0] FLIT_PAYLOAD = 2'b00;
   localparam logic [1:0] FLIT_LAST    = 2'b01;
   localparam logic [1:0] FLIT_SINGLE  = 2'b11;

   localparam int TYPE_MSB = 33;
   localparam int TYPE_LSB = 32;

   typedef enum logic {IDLE, PAYLOAD} tx_state_t;

   // Header layout from the MSB down: dest, 3-bit class, source, zero fill.
   function automatic int noc_dest_lsb(input int dest_width);
      return 32 - dest_width;
   endfunction

   function automatic int noc_class_lsb(input int dest_width);
      return 32 - dest_width - 3;
   endfunction

   function automatic int noc_src_lsb(input int dest_width);
      return 32 - 2 * dest_width - 3;
   endfunction

   function automatic logic [31:0] noc_make_header(
      input logic [31:0] dest,
      input logic [2:0]  cls,
      input logic [31:0] src,
      input int          dest_width
   );
      logic [31:0] id_mask;
      logic [31:0] hdr;
      id_mask = (32'h1 << dest_width) - 32'h1;
      hdr = ((dest & id_mask) << noc_dest_lsb(dest_width))
          | ({29'd0, cls}     << noc_class_lsb(dest_width))
          | ((src & id_mask)  << noc_src_lsb(dest_width));
      return hdr;
   endfunction

endpackage

// File: rtl/noc_packet_tx.sv
// Transmit packetizer: request + payload stream -> registered flit stream.
// Optional flit/packet counters are enabled with NOC_PACKET_TX_STATS_EN.
module noc_packet_tx
   import noc_pkg::*;
#(
   parameter int FLIT_WIDTH = 34,
   parameter int DEST_WIDTH = 5,
   parameter int MAX_LEN    = 8,
   parameter int SRC_ID     = 0,
   localparam int LEN_W     = $clog2(MAX_LEN + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [DEST_WIDTH-1:0] req_dest,
   input  logic [2:0]            req_class,
   input  logic [LEN_W-1:0]      req_len,
   input  logic [31:0]           data_in,
   input  logic                  data_valid,
   output logic                  data_ready,
   output logic [FLIT_WIDTH-1:0] out_flit,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  len_err
`ifdef NOC_PACKET_TX_STATS_EN
   ,
   output logic [15:0]           stat_pkts,
   output logic [15:0]           stat_flits
`endif
);

   localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
   localparam logic [LEN_W-1:0] ONE_L     = LEN_W'(1);

   tx_state_t             state_q, state_d;
   logic [LEN_W-1:0]      remaining_q, remaining_d;
   logic [FLIT_WIDTH-1:0] out_flit_q, out_flit_d;
   logic                  out_valid_q, out_valid_d;
   logic                  len_err_q, len_err_d;
   logic                  free;
   logic [LEN_W-1:0]      eff_len;
   logic [31:0]           hdr_data;

   assign free     = ~out_valid_q | out_ready;
   assign hdr_data = noc_make_header(32'(req_dest), req_class, 32'(SRC_ID), DEST_WIDTH);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         remaining_q <= '0;
         out_flit_q  <= '0;
         out_valid_q <= 1'b0;
         len_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         out_flit_q  <= out_flit_d;
         out_valid_q <= out_valid_d;
         len_err_q   <= len_err_d;
      end
   end

   // Ready outputs are held low during reset so nothing is accepted until the
   // registered state is valid. A free slot with no load drops out_valid.
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      out_flit_d  = out_flit_q;
      out_valid_d = out_valid_q;
      len_err_d   = 1'b0;
      req_ready   = 1'b0;
      data_ready  = 1'b0;
      eff_len     = (req_len > MAX_LEN_L) ? MAX_LEN_L : req_len;

      if (free) begin
         out_valid_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            req_ready = free & ~rst;
            if (req_valid && req_ready) begin
               out_valid_d = 1'b1;
               len_err_d   = (req_len > MAX_LEN_L);
               if (eff_len == '0) begin
                  out_flit_d = FLIT_WIDTH'({FLIT_SINGLE, hdr_data});
               end else begin
                  out_flit_d  = FLIT_WIDTH'({FLIT_HEADER, hdr_data});
                  remaining_d = eff_len;
                  state_d     = PAYLOAD;
               end
            end
         end
         PAYLOAD: begin
            data_ready = free & ~rst;
            if (data_valid && data_ready) begin
               out_valid_d = 1'b1;
               remaining_d = remaining_q - ONE_L;
               if (remaining_q == ONE_L) begin
                  out_flit_d = FLIT_WIDTH'({FLIT_LAST, data_in});
                  state_d    = IDLE;
               end else begin
                  out_flit_d = FLIT_WIDTH'({FLIT_PAYLOAD, data_in});
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign out_flit  = out_flit_q;
   assign out_valid = out_valid_q;
   assign len_err   = len_err_q;

`ifdef NOC_PACKET_TX_STATS_EN
   logic [15:0] stat_pkts_q;
   logic [15:0] stat_flits_q;
   logic        handoff;

   assign handoff = out_valid_q & out_ready;

   // HEADER and SINGLE both have the type MSB set, marking a packet start.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_pkts_q  <= '0;
         stat_flits_q <= '0;
      end else if (handoff) begin
         stat_flits_q <= stat_flits_q + 16'd1;
         if (out_flit_q[TYPE_MSB]) begin
            stat_pkts_q <= stat_pkts_q + 16'd1;
         end
      end
   end

   assign stat_pkts  = stat_pkts_q;
   assign stat_flits = stat_flits_q;
`endif

endmodule
